// File: rtl/pat_scan_ctrl_pkg.sv
// Shared types for the bit-serial pattern detector family.
package pat_scan_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/pat_scan_ctrl_if.sv
// Host-side bundle of the pattern scan sequencer: request/operands in, status/results out.
interface pat_scan_ctrl_if #(
    parameter int DW = 16,
    parameter int PW = 5,
    parameter int CW = 5
);
    logic          start;
    logic [DW-1:0] data_in;
    logic [PW-1:0] pat;
    logic          busy;
    logic          done;
    logic          bit_o;
    logic          hit;
    logic [CW-1:0] match_cnt;

    modport master (
        output start, data_in, pat,
        input  busy, done, bit_o, hit, match_cnt
    );

    modport slave (
        input  start, data_in, pat,
        output busy, done, bit_o, hit, match_cnt
    );
endinterface

// File: rtl/pat_window_match.sv
// Sliding PW-bit window with fill counter and combinational match look-ahead.
// PAT_NOOVL_EN defined: a hit clears the fill counter (non-overlapping matches).
module pat_window_match #(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          clr,
    input  logic          shift_en,
    input  logic          bit_in,
    input  logic [PW-1:0] pat,
    output logic          match_nxt
);
    localparam int FW = $clog2(PW + 1);

    logic [PW-1:0] window;
    logic [PW-1:0] window_nxt;
    logic [FW-1:0] fill;
    logic          full_nxt;

    // The incoming bit completes PW valid bits once PW-1 are already held.
    always_comb begin
        window_nxt = {window[PW-2:0], bit_in};
        full_nxt   = (fill >= FW'(PW - 1));
        match_nxt  = shift_en && full_nxt && (window_nxt == pat);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            window <= '0;
            fill   <= '0;
        end else if (clr) begin
            window <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            window <= window_nxt;
`ifdef PAT_NOOVL_EN
            if (match_nxt)
                fill <= '0;
            else if (fill != FW'(PW))
                fill <= fill + 1'b1;
`else
            if (fill != FW'(PW))
                fill <= fill + 1'b1;
`endif
        end
    end
endmodule

// File: rtl/pat_scan_ctrl.sv
// Word-level sequencer: latches a word/pattern, shifts it MSB-first into the matcher, counts hits.
// Overlap behaviour selected by PAT_NOOVL_EN (see pat_window_match).
module pat_scan_ctrl
    import pat_scan_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int PW = 5,
    parameter int CW = 5
) (
    input  logic                 clk,
    input  logic                 rst_b,
    pat_scan_ctrl_if.slave       bus
);
    localparam int IW = (DW > 1) ? $clog2(DW) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] data_q;
    logic [PW-1:0] pat_q;
    logic [IW-1:0] idx;
    logic [CW-1:0] match_cnt;
    logic          bit_q;
    logic          hit_q;
    logic          accept;
    logic          shift_en;
    logic          match_nxt;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (idx == IW'(DW - 1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_q    <= '0;
            pat_q     <= '0;
            idx       <= '0;
            match_cnt <= '0;
            bit_q     <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            bit_q <= shift_en & data_q[DW-1];
            hit_q <= match_nxt;
            if (accept) begin
                data_q    <= bus.data_in;
                pat_q     <= bus.pat;
                idx       <= '0;
                match_cnt <= '0;
            end else if (shift_en) begin
                data_q <= {data_q[DW-2:0], 1'b0};
                idx    <= idx + 1'b1;
                if (match_nxt && (match_cnt != '1))
                    match_cnt <= match_cnt + 1'b1;
            end
        end
    end

    pat_window_match #(
        .PW (PW)
    ) u_match (
        .clk       (clk),
        .rst_b     (rst_b),
        .clr       (accept),
        .shift_en  (shift_en),
        .bit_in    (data_q[DW-1]),
        .pat       (pat_q),
        .match_nxt (match_nxt)
    );

    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.bit_o     = bit_q;
    assign bus.hit       = hit_q;
    assign bus.match_cnt = match_cnt;
endmodule

// File: tb/tb_pat_scan_ctrl.sv
// Scoreboard bench for pat_scan_ctrl: a CW=5 and a CW=3 instance driven in lockstep.
module tb_pat_scan_ctrl;
    localparam int DW  = 16;
    localparam int PW  = 5;
    localparam int CW0 = 5;
    localparam int CW1 = 3;
`ifdef PAT_NOOVL_EN
    localparam bit NOOVL = 1'b1;
`else
    localparam bit NOOVL = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            raw;
        logic [DW:0]   mask;   // mask[k+1] set when the bit at index k ends a counted match
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [PW-1:0] pat = '0;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pat_scan_ctrl_if #(.DW(DW), .PW(PW), .CW(CW0)) bus0 ();
    pat_scan_ctrl_if #(.DW(DW), .PW(PW), .CW(CW1)) bus1 ();

    assign bus0.start = start;
    assign bus0.data_in = data_in;
    assign bus0.pat = pat;
    assign bus1.start = start;
    assign bus1.data_in = data_in;
    assign bus1.pat = pat;

    pat_scan_ctrl #(.DW(DW), .PW(PW), .CW(CW0)) u0 (.clk(clk), .rst_b(rst_b), .bus(bus0));
    pat_scan_ctrl #(.DW(DW), .PW(PW), .CW(CW1)) u1 (.clk(clk), .rst_b(rst_b), .bus(bus1));

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic int sat(input int raw, input int cw);
        int mx = (1 << cw) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    // Reference: examine every PW-bit window of the word, first bit = MSB.
    function automatic exp_t model(input logic [DW-1:0] d, input logic [PW-1:0] p);
        exp_t          e;
        int            last = -100;
        logic [PW-1:0] w;
        e.data = d;
        e.raw  = 0;
        e.mask = '0;
        for (int en = PW - 1; en < DW; en++) begin
            for (int j = 0; j < PW; j++)
                w[PW-1-j] = d[DW-1-(en-PW+1+j)];
            if (w == p && (!NOOVL || (en - last) >= PW)) begin
                e.raw++;
                e.mask[en+1] = 1'b1;
                last = en;
            end
        end
        return e;
    endfunction

    task automatic do_scan(input logic [DW-1:0] d, input logic [PW-1:0] p,
                           input int poke_at, input int abort_at);
        exp_t e;
        bit   got;
        int   cnt;
        e = model(d, p);
        @(posedge clk); #1;
        start = 1'b1; data_in = d; pat = p;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; data_in = DW'($urandom); pat = PW'($urandom);
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #1;
            cnt = 0;
            for (int i = 0; i <= abort_at; i++) cnt += int'(e.mask[i]);
            check("pre_rst_hit", bus0.hit, e.mask[abort_at]);
            check("pre_rst_cnt", bus0.match_cnt, cnt);
            rst_b = 1'b0;
            exp_q.delete();
            #1;
            check("rst_busy", bus0.busy, 0);
            check("rst_hit", bus0.hit, 0);
            check("rst_cnt", bus0.match_cnt, 0);
            check("rst_done", bus0.done, 0);
            check("rst_cnt_cw3", bus1.match_cnt, 0);
            @(negedge clk); rst_b = 1'b1;
            repeat (3) @(negedge clk);
            return;
        end
        if (poke_at > 0) begin
            repeat (poke_at) @(posedge clk);
            #1;
            start = 1'b1; data_in = ~d; pat = ~p;
            @(posedge clk); #1;
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < DW + 8 && !got; i++) begin
            @(negedge clk);
            if (bus0.done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    // Monitor: bits, hits and busy length are collected per scan and scored at done.
    initial begin : monitor
        int          nb;
        logic [DW:0] obs;
        exp_t        e;
        nb  = 0;
        obs = '0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                nb  = 0;
                obs = '0;
            end else begin
                if (bus0.hit && nb <= DW) obs[nb] = 1'b1;
                if ((bus0.busy || bus0.done) && nb >= 1 && nb <= DW && exp_q.size() > 0)
                    check("bit_o", bus0.bit_o, exp_q[0].data[DW-nb]);
                if (bus0.done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("busy_cycles", nb, DW);
                        check("hit_mask", obs, e.mask);
                        check("match_cnt", bus0.match_cnt, sat(e.raw, CW0));
                        check("match_cnt_cw3", bus1.match_cnt, sat(e.raw, CW1));
                        check("done_cw3", bus1.done, 1);
                    end
                    nb  = 0;
                    obs = '0;
                end else if (bus0.busy) begin
                    nb++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        #12;
        check("reset_busy", bus0.busy, 0);
        check("reset_done", bus0.done, 0);
        check("reset_bit_o", bus0.bit_o, 0);
        check("reset_hit", bus0.hit, 0);
        check("reset_cnt", bus0.match_cnt, 0);
        check("reset_cnt_cw3", bus1.match_cnt, 0);
        @(negedge clk); rst_b = 1'b1;
        repeat (2) @(negedge clk);

        do_scan(16'hB6B0, 5'b10110, 0, 0);
        do_scan(16'h0000, 5'b10110, 0, 0);
        do_scan(16'hFFFF, 5'b11111, 0, 0);
        do_scan(16'hB6B0, 5'b10110, 4, 0);
        do_scan(16'hAAAA, 5'b10101, 0, 0);
        do_scan(16'hB6B0, 5'b10110, 0, 8);
        do_scan(16'hB6B0, 5'b10110, 0, 0);
        for (int n = 0; n < 30; n++) begin
            logic [DW-1:0] d;
            logic [PW-1:0] p;
            d = DW'($urandom);
            p = PW'($urandom);
            if (n % 3 == 0) d = {3{p}} >> $urandom_range(0, 2);
            do_scan(d, p, (n % 4 == 1) ? int'($urandom_range(1, DW - 3)) : 0, 0);
        end
        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
